uart_tx: RTL and testbench

Byte-oriented UART transmitter with a write-side FIFO, driving the board-level `txd` pin. It sits between the I/O bus decoder and the pin. The bus decoder pushes bytes on CPU stores to the UART data address and reads `full`, `empty` and `busy` back as status. Frames are 8N1, LSB first, with a fixed integer baud divisor.

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; pops the next byte straight out of
// STOP so queued frames go out back-to-back with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_empty;

    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd, r_busy;

    logic          w_push, w_pop, w_tick;
    logic          w_txd_nxt, w_busy_nxt;
    logic [CW-1:0] w_count_nxt;

    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;
    assign busy  = r_busy;
    assign txd   = r_txd;

    // full is the registered pre-edge flag, so a push while full drops even on a pop edge
    assign w_push      = wr_en & ~r_full;
    assign w_tick      = (r_baud == BAUD_LAST);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (n_reset && w_push)
            r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA:  if (w_tick && r_bit == 3'd7) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    if (!r_empty) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop)
            w_shift_nxt = r_mem[r_rptr];
        else if (r_state == S_DATA && w_tick)
            w_shift_nxt = {1'b0, r_shift[7:1]};
    end

    // txd/busy are registered from the next state so the pin moves on the transition edge
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_baud  <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + BW'(1);
            if (r_state != S_DATA)
                r_bit <= '0;
            else if (w_tick)
                r_bit <= r_bit + 3'd1;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a timeline model (each accepted byte gets a frame start
// edge) predicts txd/busy/count/full/empty after every clock edge.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, busy, txd;
    logic [CW-1:0] count;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .busy    (busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    // k: push edge, s: edge at which the byte is popped and its start bit begins
    typedef struct {
        int         k;
        int         s;
        logic [7:0] d;
    } ent_t;

    ent_t q[$];
    int   ecnt = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic we, input logic [7:0] d);
        int pre;
        int st;
        if (!rst_n) begin
            q.delete();
            return;
        end
        if (we) begin
            pre = 0;
            foreach (q[i]) if (q[i].s >= ecnt) pre++;
            if (pre < DEPTH) begin
                st = ecnt + 1;
                if (q.size() > 0 && q[$].s + FRAME > st) st = q[$].s + FRAME;
                q.push_back('{k: ecnt, s: st, d: d});
            end
        end
    endtask

    task automatic check_outputs();
        int   cnt = 0;
        int   off;
        logic exp_busy = 1'b0;
        logic exp_txd = 1'b1;
        foreach (q[i]) begin
            if (q[i].s > ecnt) cnt++;
            if (q[i].s <= ecnt && ecnt < q[i].s + FRAME) begin
                exp_busy = 1'b1;
                off = (ecnt - q[i].s) / CPB;
                if (off == 0)      exp_txd = 1'b0;
                else if (off == 9) exp_txd = 1'b1;
                else               exp_txd = q[i].d[off-1];
            end
        end
        chk($sformatf("txd@%0d", ecnt),   txd,   exp_txd);
        chk($sformatf("busy@%0d", ecnt),  busy,  exp_busy);
        chk($sformatf("count@%0d", ecnt), count, cnt);
        chk($sformatf("empty@%0d", ecnt), empty, cnt == 0);
        chk($sformatf("full@%0d", ecnt),  full,  cnt == DEPTH);
    endtask

    task automatic step(input logic rst_n, input logic we, input logic [7:0] d);
        n_reset = rst_n;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        ecnt++;
        model_edge(rst_n, we, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        // reset
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        idle(1);

        // single byte
        step(1'b1, 1'b1, 8'h55);
        idle(45);

        // back-to-back
        step(1'b1, 1'b1, 8'hA3);
        step(1'b1, 1'b1, 8'h0F);
        idle(85);

        // overflow: 0x06 must be dropped
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 8'(i));
            if (i == 5) begin
                chk("ovf_full", full, 1);
                chk("ovf_count", count, 4);
            end
        end
        chk("ovf_count_after_drop", count, 4);
        idle(5 * FRAME + 5);

        // push on the very edge STOP pops the queued byte
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        idle(39);
        step(1'b1, 1'b1, 8'h33);
        chk("pp_count", count, 1);
        idle(3 * FRAME + 10);

        // reset during data bit 3 with two bytes queued
        step(1'b1, 1'b1, 8'hC6);
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'h3C);
        idle(15);
        chk("mid_count_before", count, 2);
        step(1'b0, 1'b1, 8'hFF);
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        idle(60);

        // randomized traffic with rare resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            else
                step(1'b1, ($urandom_range(0, 29) == 0), 8'($urandom));
        end
        idle(DEPTH * FRAME + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
